// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry constants, FSM state type and address helper
// for the L1 data-cache controller (2-way, 16 sets, 256-bit lines).
package dcache_pkg;

    localparam int TAG_W      = 23;
    localparam int INDEX_W    = 4;
    localparam int LINE_W     = 256;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;
    localparam int SRAM_TAG_W = TAG_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    // Byte address of the first byte of a cache line.
    function automatic logic [31:0] line_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index
    );
        return {tag, index, 5'b0};
    endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// dcache_word_mux: selects one 32-bit word from a 256-bit line for loads and
// builds the store-merged line. Ports: line, sel, wdata in; rdata, merged out.
module dcache_word_mux
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]     line,
    input  logic [WORD_SEL_W-1:0] sel,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata,
    output logic [LINE_W-1:0]     merged
);

    logic [7:0] bit_base;

    assign bit_base = {sel, 5'b0};

    always_comb begin
        rdata                    = line[bit_base +: WORD_W];
        merged                   = line;
        merged[bit_base +: WORD_W] = wdata;
    end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: write-back, write-allocate L1 dcache controller between
// the CPU MEM stage, the 2-way dcache SRAM and the 256-bit data memory.
// Ports: clk_i/rst_i; cpu_* request/response and stall; mem_* line
// interface (registered request side); cache_sram_* index/tag/data drive
// plus sram_tag_i/sram_data_i/sram_hit_i from the SRAM lookup.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [INDEX_W-1:0]    cache_sram_index_o,
    output logic [SRAM_TAG_W-1:0] cache_sram_tag_o,
    output logic [LINE_W-1:0]     cache_sram_data_o,
    output logic                  cache_sram_enable_o,
    output logic                  cache_sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i
);

    state_t                  state;
    logic [TAG_W-1:0]        tag;
    logic [INDEX_W-1:0]      index;
    logic [WORD_SEL_W-1:0]   word;
    logic                    req;
    logic                    idle;
    logic                    victim_dirty;
    logic                    write_hit;
    logic                    refill_write;
    logic [LINE_W-1:0]       merged_line;
    logic                    byte_offset_unused;

    assign tag   = cpu_addr_i[31:9];
    assign index = cpu_addr_i[8:5];
    assign word  = cpu_addr_i[4:2];
    assign byte_offset_unused = ^cpu_addr_i[1:0];

    assign req  = cpu_MemRead_i | cpu_MemWrite_i;
    assign idle = (state == IDLE);

    assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

    // Stores only write the SRAM from IDLE; a store that missed is
    // retried there once the refilled line is resident.
    assign write_hit    = idle & cpu_MemWrite_i & sram_hit_i;
    assign refill_write = (state == READMISS) & mem_ack_i;

    dcache_word_mux u_word_mux (
        .line   (sram_data_i),
        .sel    (word),
        .wdata  (cpu_data_i),
        .rdata  (cpu_data_o),
        .merged (merged_line)
    );

    assign cpu_stall_o = (idle & req & ~sram_hit_i) | ~idle;

    assign cache_sram_index_o  = index;
    assign cache_sram_enable_o = idle ? req : 1'b1;
    assign cache_sram_write_o  = ~rst_i & (write_hit | refill_write);
    assign cache_sram_data_o   = refill_write ? mem_data_i : merged_line;
    // Refilled lines are clean; store hits mark the line dirty.
    assign cache_sram_tag_o    = {1'b1, ~refill_write, tag};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req & ~sram_hit_i) begin
                        state <= MISS;
                    end
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_dirty) begin
                        mem_data_o  <= sram_data_i;
                        mem_addr_o  <= line_addr(sram_tag_i[TAG_W-1:0], index);
                        mem_write_o <= 1'b1;
                        state       <= WRITEBACK;
                    end else begin
                        mem_addr_o  <= line_addr(tag, index);
                        mem_write_o <= 1'b0;
                        state       <= READMISS;
                    end
                end
                WRITEBACK: begin
                    // Enable stays high: the refill read follows the
                    // write-back ack directly.
                    if (mem_ack_i) begin
                        mem_addr_o  <= line_addr(tag, index);
                        mem_write_o <= 1'b0;
                        state       <= READMISS;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        state        <= READMISSOK;
                    end
                end
                READMISSOK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed bench for dcache_controller with a 2-way
// LRU SRAM model, a latency-programmable memory and an architectural model.
module tb_dcache_controller;

    logic         clk;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [3:0]   cache_sram_index_o;
    logic [24:0]  cache_sram_tag_o;
    logic [255:0] cache_sram_data_o;
    logic         cache_sram_enable_o;
    logic         cache_sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    dcache_controller dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .cpu_addr_i          (cpu_addr_i),
        .cpu_data_i          (cpu_data_i),
        .cpu_MemRead_i       (cpu_MemRead_i),
        .cpu_MemWrite_i      (cpu_MemWrite_i),
        .cpu_data_o          (cpu_data_o),
        .cpu_stall_o         (cpu_stall_o),
        .mem_data_i          (mem_data_i),
        .mem_ack_i           (mem_ack_i),
        .mem_data_o          (mem_data_o),
        .mem_addr_o          (mem_addr_o),
        .mem_enable_o        (mem_enable_o),
        .mem_write_o         (mem_write_o),
        .cache_sram_index_o  (cache_sram_index_o),
        .cache_sram_tag_o    (cache_sram_tag_o),
        .cache_sram_data_o   (cache_sram_data_o),
        .cache_sram_enable_o (cache_sram_enable_o),
        .cache_sram_write_o  (cache_sram_write_o),
        .sram_tag_i          (sram_tag_i),
        .sram_data_i         (sram_data_i),
        .sram_hit_i          (sram_hit_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural memory (what loads must return) and backing DRAM.
    logic [31:0] arch [int unsigned];
    logic [31:0] dram [int unsigned];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return pat(a);
    endfunction

    function automatic logic [31:0] dram_rd(input logic [31:0] a);
        if (dram.exists(a)) return dram[a];
        return pat(a);
    endfunction

    function automatic logic [255:0] arch_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_rd(base + 32'(i*4));
        return l;
    endfunction

    // SRAM model: 2 ways, LRU, invalid way preferred as victim.
    logic [22:0]  vtag  [16][2];
    logic         vv    [16][2];
    logic         vd    [16][2];
    logic [255:0] vdata [16][2];
    logic         mru   [16];
    logic         sram_clr;
    logic [3:0]   si;
    logic [22:0]  st;
    logic         h0, h1, sw;

    assign si = cache_sram_index_o;
    assign st = cache_sram_tag_o[22:0];

    always_comb begin
        h0 = vv[si][0] && (vtag[si][0] == st);
        h1 = vv[si][1] && (vtag[si][1] == st);
        if (h0 || h1) sw = h1;
        else if (!vv[si][0]) sw = 1'b0;
        else if (!vv[si][1]) sw = 1'b1;
        else sw = !mru[si];
        sram_hit_i  = h0 || h1;
        sram_tag_i  = {vv[si][sw], vd[si][sw], vtag[si][sw]};
        sram_data_i = vdata[si][sw];
    end

    always @(posedge clk) begin
        if (sram_clr) begin
            for (int s = 0; s < 16; s++) begin
                for (int w = 0; w < 2; w++) begin
                    vv[s][w]    <= 1'b0;
                    vd[s][w]    <= 1'b0;
                    vtag[s][w]  <= '0;
                    vdata[s][w] <= '0;
                end
                mru[s] <= 1'b0;
            end
        end else if (cache_sram_enable_o) begin
            if (cache_sram_write_o) begin
                vtag[si][sw]  <= st;
                vv[si][sw]    <= cache_sram_tag_o[24];
                vd[si][sw]    <= cache_sram_tag_o[23];
                vdata[si][sw] <= cache_sram_data_o;
                mru[si]       <= sw;
            end else if (sram_hit_i) begin
                mru[si] <= sw;
            end
        end
    end

    // Memory responder: ack arrives lat cycles after enable is seen.
    int          lat = 0;
    logic        force_ack = 1'b0;
    int          wb_count = 0;
    logic [31:0] last_wb_addr = '0;
    logic [31:0] last_wb_word0 = '0;
    logic [31:0] last_rd_addr = '0;

    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            mem_ack_i = force_ack;
            if (mem_enable_o && !rst_i) begin
                if (cnt >= lat) begin
                    cnt = 0;
                    mem_ack_i = 1'b1;
                    if (mem_write_o) begin
                        chk("wb_other_line",
                            256'(mem_addr_o != {cpu_addr_i[31:5], 5'b0}),
                            256'(1));
                        chk("wb_data", mem_data_o, arch_line(mem_addr_o));
                        for (int i = 0; i < 8; i++)
                            dram[mem_addr_o + 32'(i*4)] = mem_data_o[i*32 +: 32];
                        wb_count++;
                        last_wb_addr  = mem_addr_o;
                        last_wb_word0 = mem_data_o[31:0];
                    end else begin
                        chk("rd_addr", 256'(mem_addr_o),
                            256'({cpu_addr_i[31:5], 5'b0}));
                        for (int i = 0; i < 8; i++)
                            mem_data_i[i*32 +: 32] = dram_rd(mem_addr_o + 32'(i*4));
                        last_rd_addr = mem_addr_o;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle compare against the architectural model.
    initial begin
        logic req;
        logic [255:0] exp_line;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_i) begin
                req = cpu_MemRead_i | cpu_MemWrite_i;
                chk("sram_index", 256'(cache_sram_index_o), 256'(cpu_addr_i[8:5]));
                chk("sram_tag", 256'(cache_sram_tag_o[22:0]), 256'(cpu_addr_i[31:9]));
                chk("sram_en", 256'(cache_sram_enable_o), 256'(req | cpu_stall_o));
                chk("mem_align", 256'(mem_addr_o[4:0]), 256'(0));
                if (req && !cpu_stall_o) begin
                    if (cpu_MemRead_i) begin
                        chk("load_data", 256'(cpu_data_o),
                            256'(arch_rd({cpu_addr_i[31:2], 2'b0})));
                        chk("load_nowr", 256'(cache_sram_write_o), 256'(0));
                    end else begin
                        exp_line = arch_line({cpu_addr_i[31:5], 5'b0});
                        exp_line[{cpu_addr_i[4:2], 5'b0} +: 32] = cpu_data_i;
                        chk("store_wr", 256'(cache_sram_write_o), 256'(1));
                        chk("store_tagbits", 256'(cache_sram_tag_o[24:23]), 256'(3));
                        chk("store_line", cache_sram_data_o, exp_line);
                    end
                end
                if (!req && !cpu_stall_o)
                    chk("idle_nowr", 256'(cache_sram_write_o), 256'(0));
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int l,
                          input int exp_st, input bit lit,
                          input logic [31:0] lit_val);
        int n;
        @(posedge clk);
        #1;
        lat            = l;
        cpu_addr_i     = a;
        cpu_data_i     = wd;
        cpu_MemRead_i  = !wr;
        cpu_MemWrite_i = wr;
        n = 0;
        @(negedge clk);
        #1;
        while (cpu_stall_o && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 256'(n), 256'(exp_st));
        if (exp_st == 0) chk("hit_no_mem", 256'(mem_enable_o), 256'(0));
        if (wr) begin
            if (lit) begin
                chk("store_word_lit",
                    256'(cache_sram_data_o[{a[4:2], 5'b0} +: 32]), 256'(lit_val));
                chk("store_dirty_lit", 256'(cache_sram_tag_o[23]), 256'(1));
            end
            arch[{a[31:2], 2'b0}] = wd;
        end else if (lit) begin
            chk("load_lit", 256'(cpu_data_o), 256'(lit_val));
        end
    endtask

    logic [31:0] alt_addr [8];
    bit          alt_wr   [8];

    initial begin
        int n;
        rst_i          = 1'b1;
        sram_clr       = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        arch[32'h204]  = 32'hDEAD_BEEF;
        dram[32'h204]  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        rst_i    = 1'b0;
        sram_clr = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_wr", 256'(mem_write_o), 256'(0));

        // Clean miss on empty cache, L=2.
        do_req(0, 32'h204, 0, 2, 6, 1, 32'hDEAD_BEEF);
        chk("miss_rd_addr", 256'(last_rd_addr), 256'(32'h200));
        do_req(1, 32'h208, 32'h1234_5678, 0, 0, 1, 32'h1234_5678);
        do_req(0, 32'h208, 0, 0, 0, 1, 32'h1234_5678);
        // Store miss into the empty way with L=0, then a store hit.
        do_req(1, 32'h000, 32'h1111_1111, 0, 4, 1, 32'h1111_1111);
        do_req(1, 32'h200, 32'h2222_2222, 0, 0, 1, 32'h2222_2222);
        // Dirty LRU victim (line 0x000): write-back then refill, L=1.
        wb_count = 0;
        do_req(0, 32'h400, 0, 1, 7, 1, 32'hC0DE_0400);
        chk("wb_count", 256'(wb_count), 256'(1));
        chk("wb_addr", 256'(last_wb_addr), 256'(0));
        chk("wb_word0", 256'(last_wb_word0), 256'(32'h1111_1111));
        chk("refill_addr", 256'(last_rd_addr), 256'(32'h400));

        // Back-to-back alternating hits.
        alt_addr = '{32'h408, 32'h20C, 32'h20C, 32'h40C,
                     32'h204, 32'h404, 32'h40C, 32'h208};
        alt_wr   = '{0, 1, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++)
            do_req(alt_wr[i], alt_addr[i], 32'hA000_0000 + 32'(i), 0, 0, 0, 0);

        // Reset in READMISS with an ack in the reset cycle and a late ack.
        @(posedge clk);
        #1;
        lat            = 20;
        cpu_addr_i     = 32'h1020;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!mem_enable_o && n < 20);
        chk("rm_started", 256'(mem_enable_o), 256'(1));
        chk("rm_is_read", 256'(mem_write_o), 256'(0));
        @(posedge clk);
        #1;
        rst_i         = 1'b1;
        cpu_MemRead_i = 1'b0;
        force_ack     = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_cycle_nowr", 256'(cache_sram_write_o), 256'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("post_rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("post_rst_addr", 256'(mem_addr_o), 256'(0));
        chk("late_ack_nowr", 256'(cache_sram_write_o), 256'(0));
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("late_ack_stall", 256'(cpu_stall_o), 256'(0));
        chk("late_ack_mem_en", 256'(mem_enable_o), 256'(0));

        // The aborted line must still be absent: full clean miss again.
        do_req(0, 32'h1020, 0, 1, 5, 1, 32'hC0DE_1020);

        @(posedge clk);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
